// File: rtl/rr_response_router_if.sv
// Bundle of the router's grant and response signals.
//   master : grant/PLM side; drives grants and PLM read data, observes responses
//   slave  : rr_response_router; consumes grants/data, drives responses/collision
// Signals:
//   grant_valid    [NKERNELS]             kernel k issued a PLM access this cycle
//   grant_write    [NKERNELS]             1 = write, 0 = read
//   grant_consumer [NKERNELS][CID_W]      consumer id granted by kernel k
//   plm_rdata      [NKERNELS][VALUE_WIDTH] PLM read data of kernel k
//   responses      [NCONSUMERS][RESP_WIDTH] packed {value, was_write, valid}
//   collision      sticky error flag
interface rr_response_router_if #(
  parameter int NCONSUMERS  = 16,
  parameter int NKERNELS    = 8,
  parameter int VALUE_WIDTH = 8
);
  localparam int CID_W      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int RESP_WIDTH = VALUE_WIDTH + 2;

  logic [NKERNELS-1:0]                  grant_valid;
  logic [NKERNELS-1:0]                  grant_write;
  logic [NKERNELS-1:0][CID_W-1:0]       grant_consumer;
  logic [NKERNELS-1:0][VALUE_WIDTH-1:0] plm_rdata;
  logic [NCONSUMERS-1:0][RESP_WIDTH-1:0] responses;
  logic                                 collision;

  modport master (
    output grant_valid, grant_write, grant_consumer, plm_rdata,
    input  responses, collision
  );

  modport slave (
    input  grant_valid, grant_write, grant_consumer, plm_rdata,
    output responses, collision
  );
endinterface

// File: rtl/rr_response_router.sv
// Return path of the round-robin scheduled PLM subsystem. Each kernel's grant
// tag {valid, write, consumer} is delayed by PLM_LATENCY stages, paired with
// the kernel's PLM read data, and registered as a one-cycle response on the
// granted consumer's channel.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : rr_response_router_if slave modport (grants, PLM data in;
//           responses, sticky collision flag out)
module rr_response_router #(
  parameter int NCONSUMERS  = 16,
  parameter int NBANKS      = 4,
  parameter int NPORTS      = 2,
  parameter int VALUE_WIDTH = 8,
  parameter int PLM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_response_router_if.slave   bus
);
  localparam int NKERNELS   = NBANKS * NPORTS;
  localparam int CID_W      = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;
  localparam int RESP_WIDTH = VALUE_WIDTH + 2;
  localparam logic [CID_W:0] NC_EXT = (CID_W + 1)'(NCONSUMERS);

  typedef struct packed {
    logic             valid;
    logic             write;
    logic [CID_W-1:0] cid;
  } tag_t;

  tag_t tag_q [NKERNELS][PLM_LATENCY];

  logic [NCONSUMERS-1:0][RESP_WIDTH-1:0] resp_q, resp_d;
  logic [NCONSUMERS-1:0]                 taken;
  logic                                  coll_q, coll_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NKERNELS; k++) begin
        for (int unsigned i = 0; i < PLM_LATENCY; i++) begin
          tag_q[k][i] <= '0;
        end
      end
      resp_q <= '0;
      coll_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NKERNELS; k++) begin
        tag_q[k][0] <= '{valid: bus.grant_valid[k],
                         write: bus.grant_write[k],
                         cid:   bus.grant_consumer[k]};
        for (int unsigned i = 1; i < PLM_LATENCY; i++) begin
          tag_q[k][i] <= tag_q[k][i-1];
        end
      end
      resp_q <= resp_d;
      coll_q <= coll_q | coll_d;
    end
  end

  // Kernels are scanned in ascending order so the lowest index claims a
  // consumer first; later kernels hitting an already-claimed consumer, or an
  // id past NCONSUMERS, are dropped and flag a collision.
  always_comb begin
    resp_d = '0;
    taken  = '0;
    coll_d = 1'b0;
    for (int unsigned k = 0; k < NKERNELS; k++) begin
      if (tag_q[k][PLM_LATENCY-1].valid) begin
        if ({1'b0, tag_q[k][PLM_LATENCY-1].cid} >= NC_EXT) begin
          coll_d = 1'b1;
        end else if (taken[tag_q[k][PLM_LATENCY-1].cid]) begin
          coll_d = 1'b1;
        end else begin
          taken[tag_q[k][PLM_LATENCY-1].cid] = 1'b1;
          resp_d[tag_q[k][PLM_LATENCY-1].cid] =
            {(tag_q[k][PLM_LATENCY-1].write ? '0 : bus.plm_rdata[k]),
             tag_q[k][PLM_LATENCY-1].write, 1'b1};
        end
      end
    end
  end

  assign bus.responses = resp_q;
  assign bus.collision = coll_q;
endmodule

// File: tb/tb_rr_response_router.sv
module tb_rr_response_router;
  localparam int NC = 16;
  localparam int NK = 8;
  localparam int VW = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rr_response_router_if #(.NCONSUMERS(NC), .NKERNELS(NK), .VALUE_WIDTH(VW)) b1 ();
  rr_response_router_if #(.NCONSUMERS(NC), .NKERNELS(NK), .VALUE_WIDTH(VW)) b3 ();

  rr_response_router #(.NCONSUMERS(NC), .NBANKS(4), .NPORTS(2),
                       .VALUE_WIDTH(VW), .PLM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave));

  rr_response_router #(.NCONSUMERS(NC), .NBANKS(4), .NPORTS(2),
                       .VALUE_WIDTH(VW), .PLM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    b1.grant_valid = '0; b1.grant_write = '0; b1.grant_consumer = '0; b1.plm_rdata = '0;
    b3.grant_valid = '0; b3.grant_write = '0; b3.grant_consumer = '0; b3.plm_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NC*10-1:0] r;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b1.grant_valid = 8'($urandom); b1.grant_write = 8'($urandom);
      b1.grant_consumer = 32'($urandom); b1.plm_rdata = {$urandom, $urandom};
      b3.grant_valid = 8'($urandom); b3.grant_write = 8'($urandom);
      b3.grant_consumer = 32'($urandom); b3.plm_rdata = {$urandom, $urandom};
      step();
      r = b1.responses;
      checks++;
      if (r !== '0 || b1.collision !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut1: responses=%h collision=%b, required 0/0", r, b1.collision);
      end
      r = b3.responses;
      checks++;
      if (r !== '0 || b3.collision !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut3: responses=%h collision=%b, required 0/0", r, b3.collision);
      end
    end
    idle();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (b1.responses !== '0 || b3.responses !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d dut1=%h dut3=%h, required 0", i,
                 b1.responses, b3.responses);
      end
    end
  endtask

  task automatic test_single_read();
    b1.grant_valid[0] = 1'b1; b1.grant_write[0] = 1'b0; b1.grant_consumer[0] = 4'd3;
    step();                                   // edge E
    idle();
    b1.plm_rdata[0] = 8'h19;
    step();                                   // edge E+1
    checks++;
    if (b1.responses[3] !== 10'({8'h19, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL single_read_resp: got %h required %h", b1.responses[3], 10'h065);
    end
    for (int c = 0; c < NC; c++) begin
      if (c != 3) begin
        checks++;
        if (b1.responses[c] !== '0) begin
          errors++;
          $display("FAIL single_read_others: consumer %0d got %h required 0", c, b1.responses[c]);
        end
      end
    end
    idle();
    step();                                   // edge E+2
    checks++;
    if (b1.responses[3] !== '0) begin
      errors++;
      $display("FAIL single_read_oneshot: got %h required 0", b1.responses[3]);
    end
  endtask

  task automatic test_write_ack();
    b1.grant_valid[5] = 1'b1; b1.grant_write[5] = 1'b1; b1.grant_consumer[5] = 4'd7;
    step();
    idle();
    b1.plm_rdata[5] = 8'h5A;                  // must not leak into a write ack
    step();
    checks++;
    if (b1.responses[7] !== 10'({8'h00, 1'b1, 1'b1})) begin
      errors++;
      $display("FAIL write_ack: got %h required %h", b1.responses[7], 10'h003);
    end
    idle();
    step();
    checks++;
    if (b1.responses[7] !== '0) begin
      errors++;
      $display("FAIL write_ack_oneshot: got %h required 0", b1.responses[7]);
    end
  endtask

  task automatic test_parallel();
    for (int k = 0; k < NK; k++) begin
      b1.grant_valid[k] = 1'b1; b1.grant_write[k] = 1'b0; b1.grant_consumer[k] = 4'(k);
    end
    step();
    idle();
    for (int k = 0; k < NK; k++) b1.plm_rdata[k] = 8'(8'h10 + k);
    step();
    for (int c = 0; c < NC; c++) begin
      logic [9:0] exp;
      exp = (c < NK) ? {8'(8'h10 + c), 1'b0, 1'b1} : 10'h000;
      checks++;
      if (b1.responses[c] !== exp) begin
        errors++;
        $display("FAIL parallel: consumer %0d got %h required %h", c, b1.responses[c], exp);
      end
    end
    checks++;
    if (b1.collision !== 1'b0) begin
      errors++;
      $display("FAIL parallel_collision: got %b required 0", b1.collision);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    b1.grant_valid[3] = 1'b1; b1.grant_consumer[3] = 4'd2;
    step();                                   // E1: first grant
    b1.plm_rdata[3] = 8'h01;                  // second grant stays asserted
    step();                                   // E2
    checks++;
    if (b1.responses[2] !== 10'({8'h01, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL b2b_first: got %h required %h", b1.responses[2], 10'h005);
    end
    idle();
    b1.plm_rdata[3] = 8'h02;
    step();                                   // E3
    checks++;
    if (b1.responses[2] !== 10'({8'h02, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL b2b_second: got %h required %h", b1.responses[2], 10'h009);
    end
    idle();
    step();
    checks++;
    if (b1.responses[2] !== '0) begin
      errors++;
      $display("FAIL b2b_end: got %h required 0", b1.responses[2]);
    end
  endtask

  task automatic test_collision();
    b1.grant_valid[2] = 1'b1; b1.grant_consumer[2] = 4'd9;
    b1.grant_valid[6] = 1'b1; b1.grant_consumer[6] = 4'd9;
    step();                                   // E
    checks++;
    if (b1.collision !== 1'b0) begin
      errors++;
      $display("FAIL collision_early: got %b required 0", b1.collision);
    end
    idle();
    b1.plm_rdata[2] = 8'hAA; b1.plm_rdata[6] = 8'hBB;
    step();                                   // E+1
    checks++;
    if (b1.responses[9] !== 10'({8'hAA, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL collision_winner: got %h required %h", b1.responses[9], 10'h2A9);
    end
    checks++;
    if (b1.collision !== 1'b1) begin
      errors++;
      $display("FAIL collision_rise: got %b required 1", b1.collision);
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (b1.collision !== 1'b1) begin
        errors++;
        $display("FAIL collision_sticky: cycle %0d got %b required 1", i, b1.collision);
      end
    end
  endtask

  task automatic test_latency_reset();
    b3.grant_valid[1] = 1'b1; b3.grant_consumer[1] = 4'd4;
    step();                                   // E
    idle();
    b3.plm_rdata[1] = 8'h3C;
    for (int i = 1; i <= 4; i++) begin
      logic [9:0] exp;
      step();                                 // E+i
      exp = (i == 3) ? {8'h3C, 1'b0, 1'b1} : 10'h000;
      checks++;
      if (b3.responses[4] !== exp) begin
        errors++;
        $display("FAIL latency3: E+%0d got %h required %h", i, b3.responses[4], exp);
      end
    end
    b3.grant_valid[1] = 1'b1; b3.grant_consumer[1] = 4'd4;
    step();                                   // E'
    b3.grant_valid[1] = 1'b0;
    step();                                   // E'+1
    reset = 1'b1;                             // held across E'+2
    #1;
    checks++;
    if (b1.collision !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_collision: got %b required 0", b1.collision);
    end
    step();                                   // E'+2
    reset = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      step();
      checks++;
      if (b3.responses !== '0 || b1.responses !== '0) begin
        errors++;
        $display("FAIL reset_discards_tag: E'+%0d dut3=%h dut1=%h required 0", i,
                 b3.responses, b1.responses);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reset = 1'b0;
    test_reset();
    test_single_read();
    test_write_ack();
    test_parallel();
    test_back_to_back();
    test_collision();
    test_latency_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
